// File: rtl/seq_mult_handshake_if.sv
// Start/done handshake bundle for seq_mult_handshake.
// The master side is the requester; the slave side is the multiplier.
interface seq_mult_handshake_if #(
    parameter int unsigned WIDTH = 18
);
    logic                 calc_start;
    logic [WIDTH-1:0]     dataa;
    logic [WIDTH-1:0]     datab;
    logic [2*WIDTH-1:0]   result;
    logic                 done;
    logic                 busy;

    modport master (
        output calc_start, dataa, datab,
        input  result, done, busy
    );

    modport slave (
        input  calc_start, dataa, datab,
        output result, done, busy
    );
endinterface

// File: rtl/seq_mult_handshake.sv
// Iterative unsigned WIDTH x WIDTH multiplier behind a level start/done handshake.
// Radix-2 by default; define SEQ_MULT_RADIX4_EN to retire two multiplier bits per edge.
module seq_mult_handshake #(
    parameter int unsigned WIDTH = 18
) (
    input  logic                  CLK,
    input  logic                  RST,
    seq_mult_handshake_if.slave   bus
);

`ifdef SEQ_MULT_RADIX4_EN
    localparam int unsigned IterBits = 2;
`else
    localparam int unsigned IterBits = 1;
`endif
    localparam int unsigned Iters  = WIDTH / IterBits;
    localparam int unsigned CountW = $clog2(Iters);
    localparam int unsigned ProdW  = 2 * WIDTH;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    ma_q, ma_d;
    logic [WIDTH-1:0]    mb_q, mb_d;
    logic [ProdW-1:0]    acc_q, acc_d;
    logic [CountW-1:0]   count_q, count_d;
    logic [ProdW-1:0]    result_q, result_d;
    logic                done_q, done_d;

    logic [ProdW-1:0]    ma_ext;
    logic [ProdW-1:0]    addend;
    logic [ProdW-1:0]    acc_sum;
    logic [CountW:0]     shamt;

    // Partial product for the multiplier digit currently at the bottom of mb_q.
    always_comb begin
        ma_ext = {{WIDTH{1'b0}}, ma_q};
`ifdef SEQ_MULT_RADIX4_EN
        shamt  = {count_q, 1'b0};
        addend = (ma_ext * {{(ProdW-2){1'b0}}, mb_q[1:0]}) << shamt;
`else
        shamt  = {1'b0, count_q};
        addend = mb_q[0] ? (ma_ext << shamt) : '0;
`endif
        acc_sum = acc_q + addend;
    end

    always_comb begin
        state_d  = state_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;
        done_d   = done_q;

        unique case (state_q)
            StIdle: begin
                if (bus.calc_start) begin
                    ma_d    = bus.dataa;
                    mb_d    = bus.datab;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!bus.calc_start) begin
                    // Abort: partial accumulator is simply abandoned.
                    state_d = StIdle;
                end else begin
                    acc_d   = acc_sum;
                    mb_d    = mb_q >> IterBits;
                    count_d = count_q + CountW'(1);
                    if (count_q == CountW'(Iters - 1)) begin
                        result_d = acc_sum;
                        done_d   = 1'b1;
                        state_d  = StDone;
                    end
                end
            end
            StDone: begin
                if (!bus.calc_start) begin
                    done_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= StIdle;
            ma_q     <= '0;
            mb_q     <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;
    assign bus.busy   = (state_q == StRun);

endmodule
